// File: rtl/life_frame_gen.sv
`timescale 1ns/1ps
// life_frame_gen: Game of Life engine on an 8x8 torus feeding the LED scan driver.
// Latency: seed 64 clks; generation period GEN_DIV+65 clks (WAIT+CALC+COMMIT).
// Backpressure: none; pause holds the WAIT divider, requests are latched until serviced.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pause               freeze the inter-generation divider while in WAIT
//   reseed_req          one-cycle request for a new random board (latched)
//   load_en, load_data  load a 64-bit board; honoured only in WAIT
//   frame               current board, bit r*8+c = row r, column c
//   frame_valid         one-cycle pulse aligned with each new frame value
//   generation          generations since last seed/load (wraps)
//   reseeded            one-cycle pulse with frame_valid when a seed lands
//
// Build option: define LIFE_PERIOD2_DETECT_EN to also treat period-2
// oscillators as stagnation (keeps a copy of the previous frame).

module life_frame_gen #(
  parameter int          GEN_DIV   = 2700000,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_5EED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        reseed_req,
  input  logic        load_en,
  input  logic [63:0] load_data,
  output logic [63:0] frame,
  output logic        frame_valid,
  output logic [15:0] generation,
  output logic        reseeded
);

  localparam logic [31:0]       SEED_INIT = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0]       LFSR_MASK = 32'h8020_0003;
  localparam int                DIV_W     = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(GEN_DIV - 1);

  typedef enum logic [1:0] {
    S_SEED   = 2'd0,
    S_WAIT   = 2'd1,
    S_CALC   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [5:0]        idx;        // cell / seed bit index, shared by SEED and CALC
  logic [DIV_W-1:0]  div;
  logic              pending;
  logic [31:0]       lfsr;
  logic [31:0]       lfsr_step;
  logic [63:0]       seed_sr;
  logic [63:0]       next_r;
`ifdef LIFE_PERIOD2_DETECT_EN
  logic [63:0]       prev;
`endif

  // FSM control strobes
  logic seed_done;
  logic load_take;
  logic commit_take;
  logic div_clr;
  logic div_inc;
  logic stagnant;

  // neighbour evaluation for cell idx
  logic [2:0] row, col, rm, rp, cm, cp;
  logic [3:0] ncount;
  logic       cell_next;

  // Galois step, right-shifting form
  assign lfsr_step = {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & LFSR_MASK);

  always_comb begin
    row = idx[5:3];
    col = idx[2:0];
    rm  = row - 3'd1;   // 3-bit arithmetic gives the torus wrap for free
    rp  = row + 3'd1;
    cm  = col - 3'd1;
    cp  = col + 3'd1;
    ncount = 4'(frame[{rm, cm}]) + 4'(frame[{rm, col}]) + 4'(frame[{rm, cp}])
           + 4'(frame[{row, cm}])                       + 4'(frame[{row, cp}])
           + 4'(frame[{rp, cm}]) + 4'(frame[{rp, col}]) + 4'(frame[{rp, cp}]);
    cell_next = (ncount == 4'd3) | (frame[idx] & (ncount == 4'd2));
  end

  always_comb begin
    stagnant = (next_r == 64'h0) | (next_r == frame);
`ifdef LIFE_PERIOD2_DETECT_EN
    stagnant = stagnant | (next_r == prev);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_SEED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    seed_done   = 1'b0;
    load_take   = 1'b0;
    commit_take = 1'b0;
    div_clr     = 1'b0;
    div_inc     = 1'b0;
    case (state)
      S_SEED: begin
        if (idx == 6'd63) begin
          seed_done = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (load_en) begin
          load_take = 1'b1;
          div_clr   = 1'b1;
        end else if (pending) begin
          div_clr   = 1'b1;
          state_nxt = S_SEED;
        end else if (!pause) begin
          if (div == DIV_LAST) begin
            div_clr   = 1'b1;
            state_nxt = S_CALC;
          end else begin
            div_inc = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (idx == 6'd63) state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        if (stagnant) begin
          state_nxt = S_SEED;
        end else begin
          commit_take = 1'b1;
          state_nxt   = S_WAIT;
        end
      end
      default: state_nxt = S_SEED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame       <= 64'h0;
      frame_valid <= 1'b0;
      reseeded    <= 1'b0;
      generation  <= 16'h0;
      lfsr        <= SEED_INIT;
      div         <= '0;
      pending     <= 1'b0;
      seed_sr     <= 64'h0;
      next_r      <= 64'h0;
      idx         <= 6'd0;
`ifdef LIFE_PERIOD2_DETECT_EN
      prev        <= 64'h0;
`endif
    end else begin
      frame_valid <= 1'b0;
      reseeded    <= 1'b0;

      // A load or a finished seed both satisfy any outstanding reseed request.
      if (seed_done || load_take) pending <= 1'b0;
      else if (reseed_req)        pending <= 1'b1;

      if (div_clr)      div <= '0;
      else if (div_inc) div <= div + 1'b1;

      // idx runs only in SEED/CALC and is parked at 0 elsewhere, so both
      // phases always start from cell 0.
      if (state == S_SEED || state == S_CALC) idx <= idx + 6'd1;
      else                                    idx <= 6'd0;

      if (state == S_SEED) begin
        lfsr    <= lfsr_step;
        // The bit shifted in on step k ends up at bit k after 64 shifts.
        seed_sr <= {lfsr_step[0], seed_sr[63:1]};
      end

      if (state == S_CALC) next_r[idx] <= cell_next;

      if (seed_done) begin
        frame       <= {lfsr_step[0], seed_sr[63:1]};
        generation  <= 16'h0;
        frame_valid <= 1'b1;
        reseeded    <= 1'b1;
`ifdef LIFE_PERIOD2_DETECT_EN
        prev        <= 64'h0;
`endif
      end else if (load_take) begin
        frame       <= load_data;
        generation  <= 16'h0;
        frame_valid <= 1'b1;
`ifdef LIFE_PERIOD2_DETECT_EN
        prev        <= 64'h0;
`endif
      end else if (commit_take) begin
        frame       <= next_r;
        generation  <= generation + 16'd1;
        frame_valid <= 1'b1;
`ifdef LIFE_PERIOD2_DETECT_EN
        prev        <= frame;
`endif
      end
    end
  end

endmodule

// File: tb/tb_life_frame_gen.sv
`timescale 1ns/1ps
// tb_life_frame_gen: directed-vector bench for life_frame_gen with GEN_DIV=4.
// Latency: checks land on exact cycle counts after each load/seed/commit.
// Backpressure: n/a; bench drives pause/reseed_req/load_en directly.

module tb_life_frame_gen;

  localparam int          GEN_DIV   = 4;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_5EED;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_0038_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0000_1010_1000;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
  localparam logic [63:0] TORUS   = 64'h0100_0000_0000_0081;
  localparam logic [63:0] TORUS_N = 64'h8100_0000_0000_0081;

  logic        clk;
  logic        rst;
  logic        pause;
  logic        reseed_req;
  logic        load_en;
  logic [63:0] load_data;
  logic [63:0] frame;
  logic        frame_valid;
  logic [15:0] generation;
  logic        reseeded;

  int checks;
  int errors;

  logic [63:0] exp_seed;

  life_frame_gen #(
    .GEN_DIV   (GEN_DIV),
    .LFSR_SEED (LFSR_SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pause       (pause),
    .reseed_req  (reseed_req),
    .load_en     (load_en),
    .load_data   (load_data),
    .frame       (frame),
    .frame_valid (frame_valid),
    .generation  (generation),
    .reseeded    (reseeded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; values are sampled 1 ns after each edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle board load issued in a WAIT cycle.
  task automatic load_board(input logic [63:0] b, input logic with_req);
    load_data  = b;
    load_en    = 1'b1;
    reseed_req = with_req;
    tick(1);
    load_en    = 1'b0;
    reseed_req = 1'b0;
  endtask

  // Reference seed: 64 Galois steps from the reset value, bit 0 after step k
  // becomes board bit k.
  function automatic logic [63:0] model_seed(input logic [31:0] s);
    logic [31:0] l;
    logic [63:0] r;
    l = (s == 32'h0) ? 32'h1 : s;
    r = 64'h0;
    for (int k = 0; k < 64; k++) begin
      l    = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
      r[k] = l[0];
    end
    return r;
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    pause      = 1'b0;
    reseed_req = 1'b0;
    load_en    = 1'b0;
    load_data  = 64'h0;
    exp_seed   = model_seed(LFSR_SEED);

    // Reset state
    tick(2);
    check("rst_frame", frame, 64'h0);
    check("rst_gen", 64'(generation), 64'h0);
    check("rst_fv", 64'(frame_valid), 64'h0);
    check("rst_reseeded", 64'(reseeded), 64'h0);

    // First seed: frame_valid exactly 64 clocks after reset release
    rst = 1'b0;
    tick(63);
    check("seed0_fv_early", 64'(frame_valid), 64'h0);
    tick(1);
    check("seed0_fv", 64'(frame_valid), 64'h1);
    check("seed0_reseeded", 64'(reseeded), 64'h1);
    check("seed0_frame", frame, exp_seed);

    // Blinker, loaded together with a reseed request (load wins, request dropped)
    load_board(BLINK_H, 1'b1);
    check("blink_load_frame", frame, BLINK_H);
    check("blink_load_fv", 64'(frame_valid), 64'h1);
    check("blink_load_reseeded", 64'(reseeded), 64'h0);
    tick(68);
    check("blink_g1_early_fv", 64'(frame_valid), 64'h0);
    check("blink_g1_early_frame", frame, BLINK_H);
    tick(1);
    check("blink_g1_frame", frame, BLINK_V);
    check("blink_g1_gen", 64'(generation), 64'h1);
    check("blink_g1_fv", 64'(frame_valid), 64'h1);
    tick(69);
`ifdef LIFE_PERIOD2_DETECT_EN
    check("blink_g2_p2_fv", 64'(frame_valid), 64'h0);
    check("blink_g2_p2_frame", frame, BLINK_V);
    tick(64);
    check("blink_p2_reseeded", 64'(reseeded), 64'h1);
    check("blink_p2_gen", 64'(generation), 64'h0);
`else
    check("blink_g2_frame", frame, BLINK_H);
    check("blink_g2_gen", 64'(generation), 64'h2);
    check("blink_g2_fv", 64'(frame_valid), 64'h1);
    check("blink_g2_reseeded", 64'(reseeded), 64'h0);
`endif

    // Still life: stagnation at first COMMIT, frame held until seed lands
    load_board(BLOCK, 1'b0);
    tick(69);
    check("still_commit_fv", 64'(frame_valid), 64'h0);
    check("still_hold_frame", frame, BLOCK);
    tick(63);
    check("still_seed_early", 64'(reseeded), 64'h0);
    tick(1);
    check("still_reseeded", 64'(reseeded), 64'h1);
    check("still_fv", 64'(frame_valid), 64'h1);
    check("still_gen", 64'(generation), 64'h0);

    // Torus wrap: corner L becomes a wrapped block, which then stagnates
    load_board(TORUS, 1'b0);
    tick(69);
    check("torus_g1_frame", frame, TORUS_N);
    check("torus_g1_gen", 64'(generation), 64'h1);
    tick(69);
    check("torus_g2_fv", 64'(frame_valid), 64'h0);
    check("torus_g2_frame", frame, TORUS_N);
    tick(64);
    check("torus_reseeded", 64'(reseeded), 64'h1);
    check("torus_gen", 64'(generation), 64'h0);

    // Empty board reseeds after one generation
    load_board(64'h0, 1'b0);
    tick(69);
    check("empty_commit_fv", 64'(frame_valid), 64'h0);
    tick(64);
    check("empty_reseeded", 64'(reseeded), 64'h1);

    // Reseed request and an (ignored) load during CALC
    load_board(BLINK_H, 1'b0);
    tick(30);
    reseed_req = 1'b1;
    load_en    = 1'b1;
    load_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(1);
    reseed_req = 1'b0;
    load_en    = 1'b0;
    tick(38);
    check("calcreq_frame", frame, BLINK_V);
    check("calcreq_gen", 64'(generation), 64'h1);
    check("calcreq_fv", 64'(frame_valid), 64'h1);
    tick(64);
    check("calcreq_seed_early", 64'(reseeded), 64'h0);
    tick(1);
    check("calcreq_reseeded", 64'(reseeded), 64'h1);
    check("calcreq_gen0", 64'(generation), 64'h0);

    // Pause stretches the period by the paused WAIT cycles
    load_board(BLINK_H, 1'b0);
    pause = 1'b1;
    tick(10);
    pause = 1'b0;
    tick(68);
    check("pause_early_fv", 64'(frame_valid), 64'h0);
    tick(1);
    check("pause_fv", 64'(frame_valid), 64'h1);
    check("pause_frame", frame, BLINK_V);

    // Pending reseed beats pause
    pause      = 1'b1;
    reseed_req = 1'b1;
    tick(1);
    reseed_req = 1'b0;
    tick(64);
    check("pausereq_early", 64'(reseeded), 64'h0);
    tick(1);
    check("pausereq_reseeded", 64'(reseeded), 64'h1);
    pause = 1'b0;

    // Reset at CALC index 30 of the second generation
    load_board(BLINK_H, 1'b0);
    tick(69);
    check("rstcalc_pre_gen", 64'(generation), 64'h1);
    tick(34);
    rst = 1'b1;
    tick(1);
    check("rstcalc_frame", frame, 64'h0);
    check("rstcalc_gen", 64'(generation), 64'h0);
    check("rstcalc_fv", 64'(frame_valid), 64'h0);
    rst = 1'b0;
    tick(63);
    check("reseed1_fv_early", 64'(frame_valid), 64'h0);
    tick(1);
    check("reseed1_fv", 64'(frame_valid), 64'h1);
    check("reseed1_frame", frame, exp_seed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
